// File: rtl/z_n_csa_sub_serial_if.sv
// Handshake and operand bus for the digit-serial subtractor.
// The master drives the request and operands; the slave returns status and result.
interface z_n_csa_sub_serial_if #(
    parameter int n = 32
);
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [n-1:0] diff;
    logic         b_out;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out
    );
endinterface

// File: rtl/z_n_csa_sub_serial.sv
// Digit-serial subtractor: diff = a - b - b_in, one m-bit carry-select slice per clock.
// Computed as a + ~b + ~b_in; the borrow-out is the inverted final carry.
module z_n_csa_sub_serial #(
    parameter int k = 8,
    parameter int m = 4,
    parameter int n = k * m
) (
    input  logic                   clk,
    input  logic                   rst,
    z_n_csa_sub_serial_if.slave    bus
);
    localparam int cw = (k > 1) ? $clog2(k) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_r;
    logic [cw-1:0]  cnt_r;
    logic           carry_r;
    logic [n-1:0]   a_r;
    logic [n-1:0]   b_r;
    logic [n-1:0]   diff_r;
    logic           b_out_r;
    logic           busy_r;
    logic           done_r;

    logic [m-1:0]   slice_a_s;
    logic [m-1:0]   slice_nb_s;
    logic [m:0]     sum0_s;
    logic [m:0]     sum1_s;
    logic [m:0]     sel_s;
    logic           last_s;

    // m-bit slice add with carry-in; bit m is the slice carry-out
    function automatic logic [m:0] slice_add(input logic [m-1:0] x,
                                             input logic [m-1:0] y,
                                             input logic         cin);
        slice_add = {1'b0, x} + {1'b0, y} + {{m{1'b0}}, cin};
    endfunction

    assign slice_a_s  = a_r[32'(cnt_r) * m +: m];
    assign slice_nb_s = ~b_r[32'(cnt_r) * m +: m];
    assign last_s     = (cnt_r == cw'(k - 1));

    // Both carry hypotheses are formed in parallel; the live carry only drives the mux
    assign sum0_s = slice_add(slice_a_s, slice_nb_s, 1'b0);
    assign sum1_s = slice_add(slice_a_s, slice_nb_s, 1'b1);

    // Carry-select mux
    always_comb begin
        sel_s = sum0_s;
        if (carry_r) begin
            sel_s = sum1_s;
        end else begin
            sel_s = sum0_s;
        end
    end

    // Control FSM with registered status and result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            carry_r <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            diff_r  <= '0;
            b_out_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= ~bus.b_in;
                        cnt_r   <= '0;
                        diff_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    diff_r[32'(cnt_r) * m +: m] <= sel_s[m-1:0];
                    carry_r                     <= sel_s[m];
                    if (last_s) begin
                        b_out_r <= ~sel_s[m];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + cw'(1);
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.diff  = diff_r;
    assign bus.b_out = b_out_r;
endmodule

// File: tb/tb_z_n_csa_sub_serial.sv
// Randomized self-checking bench for z_n_csa_sub_serial against a plain-arithmetic model.
module tb_z_n_csa_sub_serial;
    localparam int K = 8;
    localparam int N = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    z_n_csa_sub_serial_if #(.n(N)) bus ();

    z_n_csa_sub_serial #(.k(K), .m(4), .n(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // 33-bit reference: bit 32 is the borrow out of a - b - b_in
    function automatic logic [32:0] ref_sub(input logic [31:0] av, input logic [31:0] bv, input logic bi);
        ref_sub = {1'b0, av} - {1'b0, bv} - {32'd0, bi};
    endfunction

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 40);
        check("done_seen", 64'(bus.done), 64'd1);
    endtask

    // Called #1 after an edge with the DUT idle or in DONE
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic bi, input string tag);
        int          cyc;
        logic [32:0] r;
        r = ref_sub(av, bv, bi);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        bus.b_in  = bi;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.b_in  = 1'($urandom_range(0, 1));
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        check({tag, "_diff_clr"}, 64'(bus.diff), 64'd0);
        wait_done(cyc);
        check({tag, "_latency"}, 64'(cyc), 64'(K));
        check({tag, "_diff"}, 64'(bus.diff), 64'(r[31:0]));
        check({tag, "_b_out"}, 64'(bus.b_out), 64'(r[32]));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
        check({tag, "_diff_hold"}, 64'(bus.diff), 64'(r[31:0]));
    endtask

    initial begin
        int          cyc;
        int          ndone;
        logic [31:0] ra;
        logic [31:0] rb;
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.b_in  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_diff", 64'(bus.diff), 64'd0);
        check("rst_b_out", 64'(bus.b_out), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "all_ones");
        run_op(32'h00000000, 32'h00000001, 1'b0, "ripple");
        run_op(32'h12345678, 32'h02345678, 1'b0, "top_slice");
        run_op(32'h00000010, 32'h00000001, 1'b0, "cross");

        // start during RUN must be ignored
        bus.start = 1'b1; bus.a = 32'h5; bus.b = 32'h3; bus.b_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.a = 32'h0; bus.b = 32'h1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("ign_pulses", 64'(ndone), 64'd1);
        check("ign_diff", 64'(bus.diff), 64'h2);
        check("ign_b_out", 64'(bus.b_out), 64'd0);

        // reset in the middle of RUN discards the operation
        bus.start = 1'b1; bus.a = 32'h12345678; bus.b = 32'h1; bus.b_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_busy", 64'(bus.busy), 64'd0);
        check("mrst_done", 64'(bus.done), 64'd0);
        check("mrst_diff", 64'(bus.diff), 64'd0);
        check("mrst_b_out", 64'(bus.b_out), 64'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) ndone++;
        end
        check("mrst_no_done", 64'(ndone), 64'd0);
        run_op(32'h00000064, 32'h00000032, 1'b1, "after_rst");

        // back-to-back with start held high
        bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd2; bus.b_in = 1'b0;
        @(posedge clk);
        #1;
        bus.a = 32'd2; bus.b = 32'd7;
        wait_done(cyc);
        check("b2b_lat1", 64'(cyc), 64'(K));
        check("b2b_diff1", 64'(bus.diff), 64'h5);
        check("b2b_bout1", 64'(bus.b_out), 64'd0);
        wait_done(cyc);
        check("b2b_gap", 64'(cyc), 64'(K + 1));
        check("b2b_diff2", 64'(bus.diff), 64'hFFFFFFFB);
        check("b2b_bout2", 64'(bus.b_out), 64'd1);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_idle", 64'(bus.busy), 64'd0);

        // randomized operands, with some equal / extreme values mixed in
        for (int i = 0; i < 30; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 4))
                0: rb = ra;
                1: ra = 32'h0;
                2: rb = 32'hFFFFFFFF;
                3: rb = ra + 32'd1;
                default: ;
            endcase
            run_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/z_n_csa_sub_serial.md
Name: z_n_csa_sub_serial

Overview:
- Digit-serial N-bit subtractor: computes diff = a - b - b_in, where b_in is the borrow-in.
- This is the inverse operation of the team's combinational N-bit carry-select adder.
- Processes one M-bit slice per clock over K cycles, using a two-way carry-select slice: both carry hypotheses are computed and one is selected.
- Used where the full-width combinational adder is too large. A start/busy/done handshake sits between the control FSM and downstream datapath consumers.

Parameters:
- k, 8, number of slices (cycles per operation)
- m, 4, slice width in bits
- n, k*m, operand width in bits

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; accepted only when busy=0
- a  input  n  minuend; sampled on the accept edge only
- b  input  n  subtrahend; sampled on the accept edge only
- b_in  input  1  borrow-in; sampled on the accept edge only
- busy  output  1  high while slices are being processed
- done  output  1  one-cycle pulse; diff and b_out are valid
- diff  output  n  a - b - b_in modulo 2^n; held after done
- b_out  output  1  borrow-out; 1 when a < b + b_in (unsigned); held after done

Behaviour:
- Reset, applied on any edge where rst=1 and overriding all else:
  - FSM returns to IDLE; slice counter = 0; carry register = 0.
  - busy=0, done=0, diff=0, b_out=0.
  - Any in-flight operation is discarded and no done is produced for it.
- Arithmetic is two's complement: diff = a + ~b + ~b_in.
  - The internal carry register initialises to ~b_in.
  - b_out = ~(carry out of slice k-1).
- FSM states are IDLE, RUN and DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE:
  - Accept edge: start=1 in IDLE or DONE.
  - On the accept edge: latch a, b and b_in; carry = ~b_in; counter = 0; diff = 0; go to RUN.
- RUN:
  - On each edge, slice i = counter is processed.
  - sel = carry. The slice result is the precomputed a[i*m +: m] + ~b[i*m +: m] + sel, chosen from the pair of hypotheses (sel=0 and sel=1).
  - diff[i*m +: m] is written with the selected result; carry is updated with the selected slice carry-out.
  - If counter = k-1: b_out = ~carry_out; go to DONE. Otherwise counter = counter + 1.
- Latency:
  - done is high for exactly one cycle, starting k edges after the accept edge (8 edges by default).
  - A new start is accepted no earlier than the DONE cycle.
- DONE:
  - Next edge goes to IDLE, unless start=1, in which case it is a new accept and goes to RUN.
  - done deasserts on that edge in both cases.
- start while busy=1 is ignored. No queueing; operand changes during RUN have no effect.
- diff and b_out hold their last values in IDLE until the next accept edge, at which point diff clears to 0 (b_out holds until the next DONE).
- Back-to-back operation: start held high continuously gives one result every k+1 cycles.
- Wrap-around: the result is modulo 2^n; there is no saturation. b_out is the only overflow indicator.
- Combinational depth per cycle is one m-bit slice plus one 2:1 mux. There is no n-bit ripple path.

Test Plan:
- a=32'hFFFFFFFF, b=32'hFFFFFFFF, b_in=1, start pulse -> done exactly 8 cycles after accept; diff=32'hFFFFFFFF, b_out=1.
- a=32'h00000000, b=32'h00000001, b_in=0 -> diff=32'hFFFFFFFF, b_out=1 (borrow ripples through all 8 slices).
- a=32'h12345678, b=32'h02345678, b_in=0 -> diff=32'h10000000, b_out=0; a=32'h00000010, b=32'h00000001 -> diff=32'h0000000F, b_out=0 (cross-slice borrow).
- Accept a=32'h5, b=32'h3; pulse start with a=32'h0, b=32'h1 at cycle 3 of RUN -> ignored; diff=32'h00000002, b_out=0, exactly one done pulse.
- Assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, diff=0, b_out=0; no done pulse follows; a fresh start then completes normally.
- start held high with operand pairs (7,2) then (2,7) -> done pulses 9 cycles apart; results 32'h5/b_out=0, then 32'hFFFFFFFB/b_out=1.
